serial_work_transmit: RTL

//  Transmit end of the 64-byte work protocol: serializes one 512-bit work unit
//   (256b midstate + 256b data2) into 64 UART bytes, MSB-first.

---
 rtl/serial_work_transmit_pkg.sv | 23 ++
 rtl/serial_work_transmit_uart.sv | 47 ++++
 rtl/serial_work_transmit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/serial_work_transmit_pkg.sv
// Shared constants for the 64-byte work protocol (transmit and receive ends).
// Purpose: work geometry, UART baud and FSM state encodings.
// Ports: none (package).
package serial_work_transmit_pkg;

  localparam int WORK_BYTES = 64;
  localparam int WORK_BITS  = 512;
  localparam int BAUD_RATE  = 115_200;

  // Transmit FSM encodings
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // One work unit as it travels on the wire: midstate first, MSB-first.
  typedef struct packed {
    logic [255:0] midstate;
    logic [255:0] data2;
  } work_t;

endpackage

// File: rtl/serial_work_transmit_uart.sv
// 8N1 UART transmitter, LSB-first, one start and one stop bit.
// Latency: TxD drops to the start bit the cycle after rx_new_byte; tx_ready
//   falls one cycle after the strobe and rises when the stop bit ends.
// Backpressure: rx_new_byte is ignored unless tx_ready is high.
// Ports: clk, rx_new_byte (start strobe), rx_byte[7:0], tx_ready, TxD (idle high).
// No reset: any power-up state drains within 15 bit times and a byte in
//   flight always completes, even if the surrounding logic is reset.
module serial_work_transmit_uart #(
  parameter int comm_clk_frequency = 109_000_000,
  parameter int baud_rate          = 115_200
) (
  input  logic       clk,
  input  logic       rx_new_byte,
  input  logic [7:0] rx_byte,
  output logic       tx_ready,
  output logic       TxD
);

  localparam int DIV = ((comm_clk_frequency / baud_rate) < 1) ? 1
                     : (comm_clk_frequency / baud_rate);
  localparam int DW  = $clog2(DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] r_div;
  logic [3:0]    r_bits;   // bits still to send, 0 = idle
  logic [9:0]    r_frame;  // {stop, data, start}, shifted out from bit 0

  always_ff @(posedge clk) begin
    if (r_bits == 4'd0) begin
      if (rx_new_byte) begin
        r_frame <= {1'b1, rx_byte, 1'b0};
        r_bits  <= 4'd10;
        r_div   <= DIV_LAST;
      end
    end else if (r_div == '0) begin
      r_frame <= {1'b1, r_frame[9:1]};
      r_bits  <= r_bits - 4'd1;
      r_div   <= DIV_LAST;
    end else begin
      r_div <= r_div - 1'b1;
    end
  end

  assign tx_ready = (r_bits == 4'd0);
  assign TxD      = tx_ready ? 1'b1 : r_frame[0];

endmodule

// File: rtl/serial_work_transmit.sv
// Serializes one 512-bit work unit {midstate, data2} into 64 UART bytes, MSB-first.
// Latency: send accept -> first start strobe 2 cycles (UART idle); tx_done once
//   the UART is ready again after byte 63.
// Backpressure: each byte waits for tx_ready; send while busy is dropped, or with
//   SERIAL_WORK_PENDING_EN defined, buffered 1-deep (latest work wins).
// Ports: clk, reset (async, active-high), midstate[255:0], data2[255:0], send,
//   busy, tx_done (1-cycle pulse), TxD (UART out, idle high).
// Build option: SERIAL_WORK_PENDING_EN enables the pending work buffer.
import serial_work_transmit_pkg::*;

module serial_work_transmit #(
  parameter int comm_clk_frequency = 109_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] midstate,
  input  logic [255:0] data2,
  input  logic         send,
  output logic         busy,
  output logic         tx_done,
  output logic         TxD
);

  localparam logic [5:0] LAST_BYTE = 6'(WORK_BYTES - 1);

  logic [2:0]           r_state;
  logic [WORK_BITS-1:0] r_shreg;
  logic [5:0]           r_byte_cnt;
  logic                 r_busy;
  logic                 r_tx_done;
  logic                 r_strobe;

  logic                 w_tx_ready;
  logic [7:0]           w_byte;
  work_t                w_work;
  logic                 w_next_vld;   // another frame ready to go at DONE
  work_t                w_next_work;

  assign w_work.midstate = midstate;
  assign w_work.data2    = data2;
  assign w_byte          = r_shreg[WORK_BITS-1 -: 8];

`ifdef SERIAL_WORK_PENDING_EN
  work_t r_pend;
  logic  r_pend_vld;

  // Pending is consumed at DONE; a send in that same cycle is loaded directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_pend_vld <= 1'b0;
    end else if (send && r_busy) begin
      r_pend     <= w_work;
      r_pend_vld <= 1'b1;
    end
  end

  // A fresh send is newer than whatever sits in pending.
  assign w_next_vld  = send | r_pend_vld;
  assign w_next_work = send ? w_work : r_pend;
`else
  assign w_next_vld  = 1'b0;
  assign w_next_work = w_work;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_byte_cnt <= '0;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
      r_strobe   <= 1'b0;
    end else begin
      r_strobe  <= 1'b0;
      r_tx_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (send && !r_busy) begin
            r_shreg    <= w_work;
            r_byte_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Strobe is registered, so it only rises after tx_ready was seen high;
          // the UART cannot go unready on its own, so it is still ready then.
          if (w_tx_ready) begin
            r_strobe <= 1'b1;
            r_state  <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Strobe is visible to the UART now; its tx_ready drops next cycle.
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_tx_ready) begin
            if (r_byte_cnt == LAST_BYTE) begin
              r_tx_done <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 6'd1;
              r_shreg    <= {r_shreg[WORK_BITS-9:0], 8'h00};
              r_state    <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          if (w_next_vld) begin
            // Chain straight into the next frame; busy never drops.
            r_shreg    <= w_next_work;
            r_byte_cnt <= '0;
            r_state    <= ST_LOAD;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign tx_done = r_tx_done;

  serial_work_transmit_uart #(
    .comm_clk_frequency (comm_clk_frequency),
    .baud_rate          (BAUD_RATE)
  ) u_uart (
    .clk         (clk),
    .rx_new_byte (r_strobe),
    .rx_byte     (w_byte),
    .tx_ready    (w_tx_ready),
    .TxD         (TxD)
  );

endmodule
